// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default datapath widths and the encodings of
// the immediate-extension mode and rt-forwarding select fields.
package pipeline_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_IMM_WIDTH  = 16;

    typedef enum logic [1:0] {
        EXT_SIGN  = 2'b00,
        EXT_ZERO  = 2'b01,
        EXT_UPPER = 2'b10,
        EXT_RSVD  = 2'b11
    } ext_mode_e;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10,
        FWD_RSVD  = 2'b11
    } fwd_sel_e;

endpackage

// File: rtl/imm_extender.sv
// Combinational immediate extender: sign, zero or upper (lui-style) placement
// of a raw instruction immediate into a full datapath word.
module imm_extender
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned IMM_WIDTH  = DEF_IMM_WIDTH
) (
    input  logic [IMM_WIDTH-1:0]  imm_in,
    input  logic [1:0]            ext_mode,
    output logic [DATA_WIDTH-1:0] ext_imm
);

    localparam int unsigned PAD_WIDTH = DATA_WIDTH - IMM_WIDTH;

    if (IMM_WIDTH < 1 || IMM_WIDTH >= DATA_WIDTH) begin : g_bad_width
        $fatal(1, "imm_extender: IMM_WIDTH must satisfy 1 <= IMM_WIDTH < DATA_WIDTH");
    end

    // Select the extension form; the reserved mode falls back to sign extension
    always_comb begin
        ext_imm = {{PAD_WIDTH{imm_in[IMM_WIDTH-1]}}, imm_in};
        case (ext_mode_e'(ext_mode))
            EXT_ZERO:  ext_imm = {{PAD_WIDTH{1'b0}}, imm_in};
            EXT_UPPER: ext_imm = {imm_in, {PAD_WIDTH{1'b0}}};
            default:   ext_imm = {{PAD_WIDTH{imm_in[IMM_WIDTH-1]}}, imm_in};
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX operand-B stage: forwards rt, selects between forwarded rt and the
// extended immediate, and registers ALU operand B plus store data with
// valid/stall/flush control.
module alu_operand_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned IMM_WIDTH  = DEF_IMM_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] read_data2,
    input  logic [IMM_WIDTH-1:0]  imm_in,
    input  logic [1:0]            ext_mode,
    input  logic                  ALUSrc,
    input  logic [1:0]            fwd_sel,
    input  logic [DATA_WIDTH-1:0] ex_mem_result,
    input  logic [DATA_WIDTH-1:0] mem_wb_result,
    output logic [DATA_WIDTH-1:0] alu_src2,
    output logic [DATA_WIDTH-1:0] store_data,
    output logic                  out_valid
);

    if (IMM_WIDTH < 1 || IMM_WIDTH >= DATA_WIDTH) begin : g_bad_width
        $fatal(1, "alu_operand_stage: IMM_WIDTH must satisfy 1 <= IMM_WIDTH < DATA_WIDTH");
    end

    logic [DATA_WIDTH-1:0] ext_imm;
    logic [DATA_WIDTH-1:0] fwd_rt;
    logic [DATA_WIDTH-1:0] operand_b;

    imm_extender #(
        .DATA_WIDTH (DATA_WIDTH),
        .IMM_WIDTH  (IMM_WIDTH)
    ) u_imm_extender (
        .imm_in   (imm_in),
        .ext_mode (ext_mode),
        .ext_imm  (ext_imm)
    );

    // Forward rt from the later pipeline stages; reserved select reads the register file
    always_comb begin
        fwd_rt = read_data2;
        case (fwd_sel_e'(fwd_sel))
            FWD_MEMWB: fwd_rt = mem_wb_result;
            FWD_EXMEM: fwd_rt = ex_mem_result;
            default:   fwd_rt = read_data2;
        endcase
    end

    // Operand B is the immediate or the forwarded rt; store data always takes rt
    always_comb begin
        operand_b = ALUSrc ? ext_imm : fwd_rt;
    end

    // ID/EX register: flush beats stall, stall holds, bubbles are forced to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            alu_src2   <= '0;
            store_data <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            alu_src2   <= '0;
            store_data <= '0;
        end else if (!stall) begin
            if (in_valid) begin
                out_valid  <= 1'b1;
                alu_src2   <= operand_b;
                store_data <= fwd_rt;
            end else begin
                out_valid  <= 1'b0;
                alu_src2   <= '0;
                store_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage (32-bit data, 16-bit immediate).
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        stall;
    logic        flush;
    logic [31:0] read_data2;
    logic [15:0] imm_in;
    logic [1:0]  ext_mode;
    logic        ALUSrc;
    logic [1:0]  fwd_sel;
    logic [31:0] ex_mem_result;
    logic [31:0] mem_wb_result;
    logic [31:0] alu_src2;
    logic [31:0] store_data;
    logic        out_valid;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Reference model state: what the EX stage should currently see
    logic        exp_valid;
    logic [31:0] exp_src2;
    logic [31:0] exp_store;

    alu_operand_stage #(
        .DATA_WIDTH (32),
        .IMM_WIDTH  (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .stall         (stall),
        .flush         (flush),
        .read_data2    (read_data2),
        .imm_in        (imm_in),
        .ext_mode      (ext_mode),
        .ALUSrc        (ALUSrc),
        .fwd_sel       (fwd_sel),
        .ex_mem_result (ex_mem_result),
        .mem_wb_result (mem_wb_result),
        .alu_src2      (alu_src2),
        .store_data    (store_data),
        .out_valid     (out_valid)
    );

    always #5 clk = ~clk;

    // Extension computed arithmetically from the mode's meaning
    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
        int s;
        if (mode == 2'd1) return 32'(imm);
        if (mode == 2'd2) return 32'(imm) * 32'd65536;
        s = $signed(imm);
        return s;
    endfunction

    function automatic logic [31:0] ref_rt(input logic [1:0] sel);
        if (sel == 2'd1) return mem_wb_result;
        if (sel == 2'd2) return ex_mem_result;
        return read_data2;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs
    task automatic model_edge();
        if (!rst_n || flush) begin
            exp_valid = 1'b0; exp_src2 = '0; exp_store = '0;
        end else if (!stall) begin
            if (in_valid) begin
                exp_valid = 1'b1;
                exp_src2  = ALUSrc ? ref_ext(imm_in, ext_mode) : ref_rt(fwd_sel);
                exp_store = ref_rt(fwd_sel);
            end else begin
                exp_valid = 1'b0; exp_src2 = '0; exp_store = '0;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        read_data2 = '0; imm_in = '0; ext_mode = '0; ALUSrc = 1'b0; fwd_sel = '0;
        ex_mem_result = '0; mem_wb_result = '0;
        exp_valid = 1'b0; exp_src2 = '0; exp_store = '0;
        tick(); tick();
        vectors++; if (out_valid !== 1'b0 || alu_src2 !== 32'h0 || store_data !== 32'h0) begin
            miscompares++; $display("FAIL reset_state: got v=%b a=%h s=%h want 0/0/0", out_valid, alu_src2, store_data); end
        rst_n = 1'b1;
        in_valid = 1'b1; ALUSrc = 1'b1; imm_in = 16'h1234; ext_mode = 2'b01;
        tick();
        vectors++; if (out_valid !== 1'b1 || alu_src2 !== 32'h0000_1234) begin
            miscompares++; $display("FAIL reset_preload: got v=%b a=%h want 1/00001234", out_valid, alu_src2); end
        #2 rst_n = 1'b0;
        #1;
        exp_valid = 1'b0; exp_src2 = '0; exp_store = '0;
        vectors++; if (out_valid !== 1'b0 || alu_src2 !== 32'h0 || store_data !== 32'h0) begin
            miscompares++; $display("FAIL reset_async: got v=%b a=%h s=%h want 0/0/0", out_valid, alu_src2, store_data); end
        tick();
        #1 rst_n = 1'b1;
        #2;
        vectors++; if (out_valid !== 1'b0 || alu_src2 !== 32'h0) begin
            miscompares++; $display("FAIL reset_release_hold: got v=%b a=%h want 0/0", out_valid, alu_src2); end
        tick();
        vectors++; if (out_valid !== 1'b1 || alu_src2 !== 32'h0000_1234) begin
            miscompares++; $display("FAIL reset_first_edge: got v=%b a=%h want 1/00001234", out_valid, alu_src2); end
    endtask

    task automatic test_ext_modes();
        logic [31:0] want [4];
        want[0] = 32'hFFFF_8001; want[1] = 32'h0000_8001; want[2] = 32'h8001_0000; want[3] = 32'hFFFF_8001;
        in_valid = 1'b1; ALUSrc = 1'b1; imm_in = 16'h8001; fwd_sel = 2'b00;
        for (int i = 0; i < 4; i++) begin
            ext_mode = 2'(i);
            tick();
            vectors++; if (alu_src2 !== want[i] || out_valid !== 1'b1) begin
                miscompares++; $display("FAIL ext_mode_%0d: got a=%h v=%b want %h/1", i, alu_src2, out_valid, want[i]); end
        end
    endtask

    task automatic test_forwarding();
        logic [31:0] want [4];
        want[0] = 32'h11; want[1] = 32'h22; want[2] = 32'h33; want[3] = 32'h11;
        in_valid = 1'b1; ALUSrc = 1'b0;
        read_data2 = 32'h11; mem_wb_result = 32'h22; ex_mem_result = 32'h33;
        for (int i = 0; i < 4; i++) begin
            fwd_sel = 2'(i);
            tick();
            vectors++; if (alu_src2 !== want[i] || store_data !== want[i]) begin
                miscompares++; $display("FAIL fwd_sel_%0d: got a=%h s=%h want %h", i, alu_src2, store_data, want[i]); end
        end
    endtask

    task automatic test_store_path();
        in_valid = 1'b1; ALUSrc = 1'b1; imm_in = 16'h0004; ext_mode = 2'b00;
        fwd_sel = 2'b10; ex_mem_result = 32'hDEAD_BEEF;
        tick();
        vectors++; if (alu_src2 !== 32'h4 || store_data !== 32'hDEAD_BEEF || out_valid !== 1'b1) begin
            miscompares++; $display("FAIL store_path: got a=%h s=%h v=%b want 00000004/deadbeef/1", alu_src2, store_data, out_valid); end
    endtask

    task automatic test_stall_flush();
        in_valid = 1'b1; ALUSrc = 1'b0; fwd_sel = 2'b00; read_data2 = 32'hAAAA;
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            read_data2 = $urandom; imm_in = 16'($urandom); ALUSrc = 1'($urandom); in_valid = 1'($urandom);
            tick();
            vectors++; if (alu_src2 !== 32'hAAAA || store_data !== 32'hAAAA || out_valid !== 1'b1) begin
                miscompares++; $display("FAIL stall_hold_%0d: got a=%h s=%h v=%b want aaaa/aaaa/1", i, alu_src2, store_data, out_valid); end
        end
        flush = 1'b1; in_valid = 1'b1;
        tick();
        vectors++; if (alu_src2 !== 32'h0 || store_data !== 32'h0 || out_valid !== 1'b0) begin
            miscompares++; $display("FAIL stall_flush: got a=%h s=%h v=%b want 0/0/0", alu_src2, store_data, out_valid); end
        flush = 1'b0;
        // Reset asserted in the middle of a stall clears everything
        in_valid = 1'b1; stall = 1'b0; ALUSrc = 1'b0; read_data2 = 32'h7777;
        tick();
        stall = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        exp_valid = 1'b0; exp_src2 = '0; exp_store = '0;
        vectors++; if (alu_src2 !== 32'h0 || out_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_mid_stall: got a=%h v=%b want 0/0", alu_src2, out_valid); end
        tick();
        #1 rst_n = 1'b1; stall = 1'b0;
    endtask

    task automatic test_bubble();
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0; ALUSrc = 1'b0; fwd_sel = 2'b00; read_data2 = 32'h55;
        tick();
        vectors++; if (out_valid !== 1'b0 || alu_src2 !== 32'h0 || store_data !== 32'h0) begin
            miscompares++; $display("FAIL bubble: got v=%b a=%h s=%h want 0/0/0", out_valid, alu_src2, store_data); end
        in_valid = 1'b1;
        tick();
        vectors++; if (out_valid !== 1'b1 || alu_src2 !== 32'h55 || store_data !== 32'h55) begin
            miscompares++; $display("FAIL bubble_recover: got v=%b a=%h s=%h want 1/55/55", out_valid, alu_src2, store_data); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 7) == 0);
            read_data2 = $urandom; ex_mem_result = $urandom; mem_wb_result = $urandom;
            imm_in = 16'($urandom); ext_mode = 2'($urandom); fwd_sel = 2'($urandom); ALUSrc = 1'($urandom);
            tick();
            vectors++; if (out_valid !== exp_valid || alu_src2 !== exp_src2 || store_data !== exp_store) begin
                miscompares++;
                $display("FAIL random_%0d: got v=%b a=%h s=%h want v=%b a=%h s=%h",
                         i, out_valid, alu_src2, store_data, exp_valid, exp_src2, exp_store);
            end
        end
        stall = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ext_modes();
        test_forwarding();
        test_store_path();
        test_stall_flush();
        test_bubble();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
